// File: rtl/wb_regfile.sv
// ============================================================================
//  Module   : wb_regfile
//  Purpose  : Writeback mux, 8-entry register file with bypassed read ports,
//             and a registered record of the most recent committed write.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module wb_regfile #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] mem_in,
  input  logic              MemToRegmux,
  input  logic              RegWrite_wb,
  input  logic [ADDR_W-1:0] rd_wb,
  input  logic              wb_stall,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              wb_valid_q,
  output logic [ADDR_W-1:0] wb_addr_q,
  output logic [DATA_W-1:0] wb_data_q,
  output logic [15:0]       wb_count
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_we;

  assign wb_data = MemToRegmux ? mem_in : alu_in;

  // Writes to r0 are dropped here, so r_regs[0] never leaves its reset value.
  assign w_we = RegWrite_wb & ~wb_stall & (rd_wb != '0);

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_we) begin
      r_regs[rd_wb] <= wb_data;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      wb_count   <= '0;
    end else begin
      wb_valid_q <= w_we;
      if (w_we) begin
        wb_addr_q <= rd_wb;
        wb_data_q <= wb_data;
        wb_count  <= wb_count + 16'd1;
      end
    end
  end

  // Reads are forced to zero during reset so a live write cannot leak through the bypass.
  assign rs_data = (!rst_n || rs_addr == '0) ? '0 :
                   (w_we && rs_addr == rd_wb) ? wb_data : r_regs[rs_addr];
  assign rt_data = (!rst_n || rt_addr == '0) ? '0 :
                   (w_we && rt_addr == rd_wb) ? wb_data : r_regs[rt_addr];

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ============================================================================
//  Module   : tb_wb_regfile
//  Purpose  : Randomized self-checking bench for wb_regfile against an array model.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/100ps
`default_nettype none

module tb_wb_regfile;

  logic       clk1 = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] alu_in = '0;
  logic [7:0] mem_in = '0;
  logic       MemToRegmux = 1'b0;
  logic       RegWrite_wb = 1'b0;
  logic [2:0] rd_wb = '0;
  logic       wb_stall = 1'b0;
  logic [2:0] rs_addr = '0;
  logic [2:0] rt_addr = '0;
  logic [7:0] wb_data, rs_data, rt_data, wb_data_q;
  logic       wb_valid_q;
  logic [2:0] wb_addr_q;
  logic [15:0] wb_count;

  wb_regfile #(.DATA_W(8), .NUM_REGS(8), .ADDR_W(3)) dut (
    .clk1(clk1), .rst_n(rst_n), .alu_in(alu_in), .mem_in(mem_in),
    .MemToRegmux(MemToRegmux), .RegWrite_wb(RegWrite_wb), .rd_wb(rd_wb),
    .wb_stall(wb_stall), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .wb_data(wb_data), .rs_data(rs_data), .rt_data(rt_data),
    .wb_valid_q(wb_valid_q), .wb_addr_q(wb_addr_q), .wb_data_q(wb_data_q),
    .wb_count(wb_count)
  );

  always #10 clk1 = ~clk1;

  int checks = 0;
  int errors = 0;

  // Architectural reference state
  logic [7:0]  m_regs [8];
  logic        m_valid;
  logic [2:0]  m_addr;
  logic [7:0]  m_data;
  logic [15:0] m_count;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_clear();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_valid = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    m_count = '0;
  endfunction

  function automatic logic m_we();
    return RegWrite_wb && !wb_stall && (rd_wb != 3'd0);
  endfunction

  function automatic logic [7:0] m_mux();
    return MemToRegmux ? mem_in : alu_in;
  endfunction

  function automatic logic [7:0] m_read(input logic [2:0] a);
    if (!rst_n || a == 3'd0) return 8'h00;
    if (m_we() && a == rd_wb) return m_mux();
    return m_regs[a];
  endfunction

  // One cycle: check combinational outputs, clock, advance model, check record.
  task automatic step(input bit comb);
    #1;
    if (comb) check_eq("wb_data", wb_data, m_mux());
    check_eq("rs_data", rs_data, m_read(rs_addr));
    check_eq("rt_data", rt_data, m_read(rt_addr));
    @(posedge clk1);
    if (rst_n) begin
      if (m_we()) begin
        m_regs[rd_wb] = m_mux();
        m_valid = 1'b1;
        m_addr  = rd_wb;
        m_data  = m_mux();
        m_count = m_count + 16'd1;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    check_eq("wb_valid_q", wb_valid_q, m_valid);
    check_eq("wb_addr_q", wb_addr_q, m_addr);
    check_eq("wb_data_q", wb_data_q, m_data);
    check_eq("wb_count", wb_count, m_count);
  endtask

  initial begin
    m_clear();
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    rst_n = 1'b1;
    #1;
    check_eq("rst_count", wb_count, 16'd0);
    check_eq("rst_valid", wb_valid_q, 1'b0);

    // ALU write to r5
    alu_in = 8'h3C; MemToRegmux = 1'b0; RegWrite_wb = 1'b1; rd_wb = 3'd5;
    rs_addr = 3'd5; rt_addr = 3'd0;
    step(1);
    RegWrite_wb = 1'b0;
    #1;
    check_eq("t2_rs", rs_data, 8'h3C);
    check_eq("t2_addr_q", wb_addr_q, 3'd5);
    check_eq("t2_data_q", wb_data_q, 8'h3C);
    check_eq("t2_count", wb_count, 16'd1);

    // Memory write to r2 with both ports bypassing
    mem_in = 8'hA5; MemToRegmux = 1'b1; RegWrite_wb = 1'b1; rd_wb = 3'd2;
    rs_addr = 3'd2; rt_addr = 3'd2;
    #1;
    check_eq("t3_rs_bypass", rs_data, 8'hA5);
    check_eq("t3_rt_bypass", rt_data, 8'hA5);
    step(1);

    // r0 write is a silent no-op
    alu_in = 8'hFF; MemToRegmux = 1'b0; rd_wb = 3'd0; rs_addr = 3'd0;
    step(1);
    check_eq("t4_r0", rs_data, 8'h00);
    check_eq("t4_valid", wb_valid_q, 1'b0);
    check_eq("t4_count", wb_count, 16'd2);

    // Stall suppresses write and bypass
    alu_in = 8'h77; rd_wb = 3'd3; rs_addr = 3'd3; rt_addr = 3'd3;
    step(1);
    alu_in = 8'h11; wb_stall = 1'b1;
    #1;
    check_eq("t5_no_bypass", rs_data, 8'h77);
    step(1);
    wb_stall = 1'b0; RegWrite_wb = 1'b0;
    #1;
    check_eq("t5_r3_kept", rt_data, 8'h77);
    check_eq("t5_count", wb_count, 16'd3);

    // Unknown mux select while not writing leaves the file intact
    MemToRegmux = 1'bx; rs_addr = 3'd5; rt_addr = 3'd2;
    step(0);
    MemToRegmux = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      alu_in      = 8'($urandom);
      mem_in      = 8'($urandom);
      MemToRegmux = 1'($urandom);
      RegWrite_wb = ($urandom_range(0, 3) != 0);
      wb_stall    = ($urandom_range(0, 3) == 0);
      rd_wb       = 3'($urandom);
      rs_addr     = ($urandom_range(0, 3) == 0) ? rd_wb : 3'($urandom);
      rt_addr     = 3'($urandom);
      step(1);
    end

    // Asynchronous reset between edges, with a write request still applied
    @(negedge clk1);
    #1;
    alu_in = 8'h5A; MemToRegmux = 1'b0; RegWrite_wb = 1'b1; wb_stall = 1'b0; rd_wb = 3'd4;
    rst_n = 1'b0;
    m_clear();
    for (int a = 0; a < 4; a++) begin
      rs_addr = 3'(2 * a);
      rt_addr = 3'(2 * a + 1);
      #1;
      check_eq("t1_rs_zero", rs_data, 8'h00);
      check_eq("t1_rt_zero", rt_data, 8'h00);
    end
    check_eq("t1_count", wb_count, 16'd0);
    check_eq("t1_valid", wb_valid_q, 1'b0);
    check_eq("t1_addr_q", wb_addr_q, 3'd0);
    check_eq("t1_data_q", wb_data_q, 8'h00);
    @(negedge clk1);
    rst_n = 1'b1;
    rs_addr = 3'd4;
    step(1);
    check_eq("post_rst_commit", wb_count, 16'd1);
    RegWrite_wb = 1'b0;
    #1;
    check_eq("post_rst_r4", rs_data, 8'h5A);

    // Counter wrap: fill to 16'hFFFF then one more commit
    RegWrite_wb = 1'b1; rd_wb = 3'd1; rs_addr = 3'd1;
    while (m_count != 16'hFFFF) begin
      alu_in = 8'($urandom);
      step(1);
    end
    check_eq("t6_preload", wb_count, 16'hFFFF);
    alu_in = 8'hC3;
    step(1);
    check_eq("t6_wrap_count", wb_count, 16'd0);
    check_eq("t6_wrap_valid", wb_valid_q, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
